// File: rtl/intersection_scheduler.sv
// intersection_scheduler: round-robin green-time arbiter for the three exclusive
// approaches of the Norton/Thevenin intersection (NN, NS, TH).
// Build option: define SCHED_NIGHT_FLASH_EN to add the `night` input and the
// flashing-yellow FLASH state; without it the outputs never show code 11.
`timescale 1ns/1ps
`default_nettype none

module intersection_scheduler #(
    parameter int CLK_HZ    = 10000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
`ifdef SCHED_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [1:0] light_nn,
    output logic [1:0] light_ns,
    output logic [1:0] light_th,
    output logic [2:0] grant,
    output logic [7:0] phase_timer
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);

    localparam logic [7:0] T_MIN = 8'(MIN_GREEN);
    localparam logic [7:0] T_MAX = 8'(MAX_GREEN);
    localparam logic [7:0] T_YEL = 8'(YELLOW);
    localparam logic [7:0] T_CLR = 8'(ALL_RED);

    localparam logic [1:0] S_ALL_RED = 2'd0;
    localparam logic [1:0] S_GREEN   = 2'd1;
    localparam logic [1:0] S_YELLOW  = 2'd2;
`ifdef SCHED_NIGHT_FLASH_EN
    localparam logic [1:0] S_FLASH   = 2'd3;
    localparam logic [1:0] LT_OFF    = 2'b11;
`endif

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    // Approach index 2 is TH; starting there makes the first search NN, NS, TH.
    localparam logic [1:0] AP_TH = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [1:0]      last, last_nxt;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [7:0]      timer_inc;
    logic [1:0][2:0] req_pipe;
    logic [2:0]      req_s;
    logic [1:0]      cand1, cand2, win;
    logic            compete, own_req;
    logic [2:0][1:0] lamp;
`ifdef SCHED_NIGHT_FLASH_EN
    logic [1:0]      night_pipe;
    logic            night_s;
    logic            flash_odd;
`endif

    // Next approach in the fixed NN -> NS -> TH -> NN ring.
    function automatic logic [1:0] inc3(input logic [1:0] a);
        return (a == 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    // Steady (non-flash) lamp code for one approach.
    function automatic logic [1:0] lamp_code(input logic [1:0] st, input logic g);
        logic [1:0] code;
        code = LT_RED;
        if (g) code = (st == S_GREEN) ? LT_GREEN : LT_YELLOW;
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous sensor requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) req_pipe <= '0;
        else          req_pipe <= {req_pipe[0], req};
    end
    assign req_s = req_pipe[1];

`ifdef SCHED_NIGHT_FLASH_EN
    // Two-flop synchronizer for the night-mode switch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) night_pipe <= '0;
        else          night_pipe <= {night_pipe[0], night};
    end
    assign night_s = night_pipe[1];
`endif

    assign tick = (presc == PRESC_TOP);

    // Value phase_timer takes next cycle; decisions compare against it so a
    // state lasts exactly N*CLK_HZ cycles from its entry cycle.
    always_comb begin
        timer_inc = phase_timer;
        if (tick && phase_timer != 8'hFF) timer_inc = phase_timer + 8'd1;
    end

    // Round-robin winner: last+1, last+2, then last itself.
    always_comb begin
        cand1 = inc3(last);
        cand2 = inc3(cand1);
        if (req_s[cand1])      win = cand1;
        else if (req_s[cand2]) win = cand2;
        else                   win = last;
    end

    assign compete = |(req_s & ~grant);
    assign own_req = |(req_s & grant);

    // Phase sequencing: ALL_RED -> GREEN -> YELLOW -> ALL_RED (+ optional FLASH).
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            S_ALL_RED: begin
                if (timer_inc >= T_CLR) begin
`ifdef SCHED_NIGHT_FLASH_EN
                    if (night_s) begin
                        state_nxt = S_FLASH;
                    end else
`endif
                    if (req_s != 3'b000) begin
                        state_nxt = S_GREEN;
                        last_nxt  = win;
                    end
                end
            end
            S_GREEN: begin
                if (compete && ((timer_inc >= T_MIN && !own_req) || timer_inc >= T_MAX))
                    state_nxt = S_YELLOW;
            end
            S_YELLOW: begin
                if (timer_inc >= T_YEL) state_nxt = S_ALL_RED;
            end
`ifdef SCHED_NIGHT_FLASH_EN
            S_FLASH: begin
                if (!night_s) state_nxt = S_ALL_RED;
            end
`endif
            default: state_nxt = S_ALL_RED;
        endcase
    end

    // State, last-served approach and the seconds timebase; both timebase
    // counters restart on every state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_ALL_RED;
            last        <= AP_TH;
            presc       <= '0;
            phase_timer <= 8'd0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (state_nxt != state) begin
                presc       <= '0;
                phase_timer <= 8'd0;
            end else begin
                presc       <= tick ? '0 : presc + 1'b1;
                phase_timer <= timer_inc;
            end
        end
    end

`ifdef SCHED_NIGHT_FLASH_EN
    // Flash phase: even seconds yellow, odd seconds dark, restarting at entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                flash_odd <= 1'b0;
        else if (state_nxt != state) flash_odd <= 1'b0;
        else if (tick)               flash_odd <= ~flash_odd;
    end
`endif

    assign grant = (state == S_GREEN || state == S_YELLOW) ? (3'b001 << last) : 3'b000;

    // Per-approach lamp decode from the state register.
    for (genvar i = 0; i < 3; i++) begin : g_lamp
`ifdef SCHED_NIGHT_FLASH_EN
        assign lamp[i] = (state == S_FLASH) ? (flash_odd ? LT_OFF : LT_YELLOW)
                                            : lamp_code(state, grant[i]);
`else
        assign lamp[i] = lamp_code(state, grant[i]);
`endif
    end

    assign light_nn = lamp[0];
    assign light_ns = lamp[1];
    assign light_th = lamp[2];

endmodule

`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler (CLK_HZ=10 timebase).
// The reference model counts cycles since state entry and applies the
// phase rules in seconds = cycles / CLK_HZ.
`timescale 1ns/1ps

module tb_intersection_scheduler;

    localparam int CLK_HZ    = 10;
    localparam int MIN_GREEN = 5;
    localparam int MAX_GREEN = 20;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;

    localparam int M_RED = 0, M_GREEN = 1, M_YEL = 2, M_FLASH = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] req = 3'b000;
    logic       night = 1'b0;
    logic [1:0] light_nn, light_ns, light_th;
    logic [2:0] grant;
    logic [7:0] phase_timer;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .CLK_HZ(CLK_HZ), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW(YELLOW), .ALL_RED(ALL_RED)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
`ifdef SCHED_NIGHT_FLASH_EN
        .night(night),
`endif
        .light_nn(light_nn),
        .light_ns(light_ns),
        .light_th(light_th),
        .grant(grant),
        .phase_timer(phase_timer)
    );

    // ---------------- reference model ----------------
    int         m_mode, m_last, m_n;
    logic [2:0] m_r1, m_rs;
    logic       m_n1, m_ns;
    int         nx_mode, nx_last, secs;

    // Decide the next mode from the rules expressed in whole seconds.
    always_comb begin
        nx_mode = m_mode;
        nx_last = m_last;
        secs    = (m_n + 1) / CLK_HZ;
        case (m_mode)
            M_RED: if (secs >= ALL_RED) begin
                if (m_ns) nx_mode = M_FLASH;
                else if (m_rs != 3'b000) begin
                    for (int k = 3; k >= 1; k--)
                        if (m_rs[(m_last + k) % 3]) nx_last = (m_last + k) % 3;
                    nx_mode = M_GREEN;
                end
            end
            M_GREEN: if ((m_rs & ~(3'b001 << m_last)) != 3'b000 &&
                         ((secs >= MIN_GREEN && !m_rs[m_last]) || secs >= MAX_GREEN))
                nx_mode = M_YEL;
            M_YEL:   if (secs >= YELLOW) nx_mode = M_RED;
            default: if (!m_ns) nx_mode = M_RED;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_RED; m_last <= 2; m_n <= 0;
            m_r1 <= 3'b000; m_rs <= 3'b000; m_n1 <= 1'b0; m_ns <= 1'b0;
        end else begin
            m_mode <= nx_mode;
            m_last <= nx_last;
            m_n    <= (nx_mode != m_mode) ? 0 : m_n + 1;
            m_r1   <= req;   m_rs <= m_r1;
            m_n1   <= night; m_ns <= m_n1;
        end
    end

    // Expected {light_nn, light_ns, light_th, grant, phase_timer}.
    function automatic logic [16:0] exp_vec();
        logic [1:0] l [3];
        logic [2:0] g;
        int t;
        g = 3'b000;
        for (int i = 0; i < 3; i++) begin
            l[i] = 2'b00;
            if (m_mode == M_FLASH)                      l[i] = ((m_n / CLK_HZ) % 2 == 1) ? 2'b11 : 2'b01;
            else if (m_last == i && m_mode == M_GREEN) l[i] = 2'b10;
            else if (m_last == i && m_mode == M_YEL)   l[i] = 2'b01;
        end
        if (m_mode == M_GREEN || m_mode == M_YEL) g[m_last] = 1'b1;
        t = m_n / CLK_HZ;
        if (t > 255) t = 255;
        return {l[0], l[1], l[2], g, 8'(t)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({light_nn, light_ns, light_th} !== 6'b000000) begin
            errors++; $display("FAIL reset_lights got %b required 000000", {light_nn, light_ns, light_th});
        end
        checks++;
        if (grant !== 3'b000) begin
            errors++; $display("FAIL reset_grant got %b required 000", grant);
        end
        checks++;
        if (phase_timer !== 8'd0) begin
            errors++; $display("FAIL reset_timer got %0d required 0", phase_timer);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({light_nn, light_ns, light_th, grant} !== 9'b0) begin
            errors++; $display("FAIL reset_held got %b required 0", {light_nn, light_ns, light_th, grant});
        end
    endtask

    task automatic test_single();
        @(negedge clk); reset_n = 1'b0; req = 3'b000;
        @(negedge clk); reset_n = 1'b1; req = 3'b010;
        for (int c = 1; c <= 310; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL single_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 9) begin
                checks++;
                if (light_ns !== 2'b00) begin
                    errors++; $display("FAIL single_early c=9 light_ns got %b required 00", light_ns);
                end
            end
            if (c == 10 || c == 310) begin
                checks++;
                if ({light_ns, grant} !== 5'b10_010) begin
                    errors++; $display("FAIL single_green c=%0d got ns=%b grant=%b required ns=10 grant=010",
                                       c, light_ns, grant);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // NS is green from the previous scenario; reset between clock edges.
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({light_nn, light_ns, light_th, grant, phase_timer} !== 17'b0) begin
            errors++; $display("FAIL reset_mid got %b required all zero",
                               {light_nn, light_ns, light_th, grant, phase_timer});
        end
        @(negedge clk); reset_n = 1'b1; req = 3'b000;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL idle_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 500) begin
                checks++;
                if ({light_nn, light_ns, light_th, grant} !== 9'b0) begin
                    errors++; $display("FAIL idle_allred got %b required 0", {light_nn, light_ns, light_th, grant});
                end
            end
        end
    endtask

    task automatic test_maxout();
        @(negedge clk); reset_n = 1'b0; req = 3'b000;
        @(negedge clk); reset_n = 1'b1; req = 3'b010;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL maxout_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 30) req = 3'b110;
            if (c == 209 || c == 210 || c == 240) begin
                checks++;
                if (light_ns !== ((c == 209) ? 2'b10 : (c == 210) ? 2'b01 : 2'b00)) begin
                    errors++; $display("FAIL maxout_ns c=%0d got %b", c, light_ns);
                end
            end
            if (c == 249 || c == 250) begin
                checks++;
                if (light_th !== ((c == 250) ? 2'b10 : 2'b00)) begin
                    errors++; $display("FAIL maxout_th c=%0d got %b required %b", c, light_th,
                                       (c == 250) ? 2'b10 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_gapout();
        @(negedge clk); reset_n = 1'b0; req = 3'b000;
        @(negedge clk); reset_n = 1'b1; req = 3'b001;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL gapout_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 20) req = 3'b100;
            if (c == 59 || c == 60) begin
                checks++;
                if (light_nn !== ((c == 60) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL gapout_nn c=%0d got %b required %b", c, light_nn,
                                       (c == 60) ? 2'b01 : 2'b10);
                end
            end
            if (c == 100) begin
                checks++;
                if (grant !== 3'b100) begin
                    errors++; $display("FAIL gapout_th c=100 grant got %b required 100", grant);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        @(negedge clk); reset_n = 1'b0; req = 3'b000;
        @(negedge clk); reset_n = 1'b1; req = 3'b111;
        for (int c = 1; c <= 740; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL rr_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 10 || c == 249 || c == 250 || c == 490 || c == 730) begin
                want = (c == 10 || c == 730) ? 3'b001 : (c == 250) ? 3'b010 :
                       (c == 490) ? 3'b100 : 3'b000;
                checks++;
                if (grant !== want) begin
                    errors++; $display("FAIL rr_order c=%0d grant got %b required %b", c, grant, want);
                end
            end
            if (c == 210) begin
                checks++;
                if (light_nn !== 2'b01) begin
                    errors++; $display("FAIL rr_nn_yellow c=210 got %b required 01", light_nn);
                end
            end
        end
    endtask

    task automatic test_random();
        @(negedge clk); reset_n = 1'b0; req = 3'b000;
        @(negedge clk); reset_n = 1'b1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL random_model c=%0d req=%b got %b required %b", c, req,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if ($urandom_range(0, 29) == 0) req = 3'($urandom_range(0, 7));
        end
    endtask

`ifdef SCHED_NIGHT_FLASH_EN
    task automatic test_flash();
        logic [5:0] want;
        @(negedge clk); reset_n = 1'b0; req = 3'b000; night = 1'b0;
        @(negedge clk); reset_n = 1'b1; req = 3'b010;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            checks++;
            if ({light_nn, light_ns, light_th, grant, phase_timer} !== exp_vec()) begin
                errors++; $display("FAIL flash_model c=%0d got %b required %b", c,
                                   {light_nn, light_ns, light_th, grant, phase_timer}, exp_vec());
            end
            if (c == 20)  req = 3'b111;
            if (c == 50)  night = 1'b1;
            if (c == 300) night = 1'b0;
            if (c == 250 || c == 260) begin
                want = (c == 250) ? 6'b01_01_01 : 6'b11_11_11;
                checks++;
                if ({light_nn, light_ns, light_th, grant} !== {want, 3'b000}) begin
                    errors++; $display("FAIL flash_lamps c=%0d got %b required %b", c,
                                       {light_nn, light_ns, light_th, grant}, {want, 3'b000});
                end
            end
            if (c == 313) begin
                checks++;
                if ({light_th, grant} !== 5'b10_100) begin
                    errors++; $display("FAIL flash_resume c=313 got th=%b grant=%b required th=10 grant=100",
                                       light_th, grant);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_maxout();
        test_gapout();
        test_round_robin();
        test_random();
`ifdef SCHED_NIGHT_FLASH_EN
        test_flash();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
